// File: rtl/mag_compare_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mag_compare_seq_pkg
//  Description : Shared types for the sequential magnitude comparator:
//                FSM state enum, result encoding and cascade resolution.
//  Revision    : 1.0 - initial release
// ============================================================================
package mag_compare_seq_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Result encoding, one bit per flag: {lt, gt, eq}
  typedef enum logic [2:0] {
    RES_NONE = 3'b000,
    RES_EQ   = 3'b001,
    RES_GT   = 3'b010,
    RES_LT   = 3'b100
  } result_t;

  localparam int c_res_eq_bit = 0;
  localparam int c_res_gt_bit = 1;
  localparam int c_res_lt_bit = 2;

  // Cascade inputs packed as {lt, gt, eq}; anything but a single hot bit
  // is treated as an invalid cascade and yields no flag at all.
  function automatic result_t resolve_cascade(input logic [2:0] casc);
    case (casc)
      3'b001:  return RES_EQ;
      3'b010:  return RES_GT;
      3'b100:  return RES_LT;
      default: return RES_NONE;
    endcase
  endfunction

endpackage : mag_compare_seq_pkg
`default_nettype wire

// File: rtl/mag_compare_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mag_compare_seq_if
//  Description : Request/result bus of the sequential magnitude comparator.
//                master = requester/consumer, slave = comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mag_compare_seq_if #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
);
  localparam int c_nchunk = WIDTH / CHUNK;
  localparam int c_cyc_w  = $clog2(c_nchunk + 1);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               aeqbin;
  logic               agtbin;
  logic               altbin;
  logic               out_valid;
  logic               out_ready;
  logic               aeqb;
  logic               agtb;
  logic               altb;
  logic [c_cyc_w-1:0] cycles;

  modport master (
    output in_valid, a, b, signed_mode, aeqbin, agtbin, altbin, out_ready,
    input  in_ready, out_valid, aeqb, agtb, altb, cycles
  );

  modport slave (
    input  in_valid, a, b, signed_mode, aeqbin, agtbin, altbin, out_ready,
    output in_ready, out_valid, aeqb, agtb, altb, cycles
  );

endinterface : mag_compare_seq_if
`default_nettype wire

// File: rtl/mag_compare_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : mag_compare_chunk
//  Description : Combinational CHUNK-bit unsigned compare. Inverting the MSB
//                of both operands turns a two's-complement top chunk into an
//                order-preserving unsigned compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module mag_compare_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             invert_msb_i,
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);

  logic [CHUNK-1:0] w_msb_mask;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;

  assign w_msb_mask = invert_msb_i ? (CHUNK'(1) << (CHUNK - 1)) : '0;
  assign w_a        = a_i ^ w_msb_mask;
  assign w_b        = b_i ^ w_msb_mask;

  assign gt_o = (w_a >  w_b);
  assign lt_o = (w_a <  w_b);
  assign eq_o = (w_a == w_b);

endmodule : mag_compare_chunk
`default_nettype wire

// File: rtl/mag_compare_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mag_compare_seq
//  Description : Sequential magnitude comparator. Walks the operands one
//                CHUNK at a time from the MSB end, stopping at the first
//                differing chunk; equal operands fall back to the cascade
//                inputs of a less-significant stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module mag_compare_seq
  import mag_compare_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mag_compare_seq_if.slave        bus_if
);

  localparam int c_nchunk = WIDTH / CHUNK;
  localparam int c_idx_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
  localparam int c_cyc_w  = $clog2(c_nchunk + 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nchunk - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("mag_compare_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, b_q;
  logic                signed_q;
  logic [2:0]          casc_q;          // {lt, gt, eq}
  logic [c_idx_w-1:0]  idx_q, idx_d;
  logic [c_cyc_w-1:0]  cnt_q, cnt_d;    // chunks examined so far
  logic [c_cyc_w-1:0]  cycles_q, cycles_d;
  result_t             res_q, res_d;

  logic                w_accept;
  logic [CHUNK-1:0]    w_a_chunk, w_b_chunk;
  logic                w_gt, w_lt, w_eq;

  assign w_accept  = (state_q == ST_IDLE) && bus_if.in_valid;
  assign w_a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign w_b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  mag_compare_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i          (w_a_chunk),
    .b_i          (w_b_chunk),
    .invert_msb_i (signed_q && (idx_q == c_last_idx)),
    .gt_o         (w_gt),
    .lt_o         (w_lt),
    .eq_o         (w_eq)
  );

  // Capture the request only on the accept cycle; held for the whole walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      casc_q   <= 3'b000;
    end else if (w_accept) begin
      a_q      <= bus_if.a;
      b_q      <= bus_if.b;
      signed_q <= bus_if.signed_mode;
      casc_q   <= {bus_if.altbin, bus_if.agtbin, bus_if.aeqbin};
    end
  end

  // State, index, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= c_last_idx;
      cnt_q    <= '0;
      cycles_q <= '0;
      res_q    <= RES_NONE;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      res_q    <= res_d;
    end
  end

  // Next-state logic: results and cycle count load only on entry to DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    res_d    = res_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.in_valid) begin
          state_d = ST_RUN;
          idx_d   = c_last_idx;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + c_cyc_w'(1);
        if (w_gt) begin
          res_d    = RES_GT;
          cycles_d = cnt_d;
          state_d  = ST_DONE;
        end else if (w_lt) begin
          res_d    = RES_LT;
          cycles_d = cnt_d;
          state_d  = ST_DONE;
        end else if (w_eq && (idx_q == '0)) begin
          res_d    = resolve_cascade(casc_q);
          cycles_d = cnt_d;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q - c_idx_w'(1);
        end
      end
      ST_DONE: begin
        if (bus_if.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_if.in_ready  = (state_q == ST_IDLE);
  assign bus_if.out_valid = (state_q == ST_DONE);
  assign bus_if.aeqb      = res_q[c_res_eq_bit];
  assign bus_if.agtb      = res_q[c_res_gt_bit];
  assign bus_if.altb      = res_q[c_res_lt_bit];
  assign bus_if.cycles    = cycles_q;

endmodule : mag_compare_seq
`default_nettype wire

// File: doc/mag_compare_seq.md
MAG_COMPARE_SEQ -- requirements
Module: mag_compare_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits.
REQ-002 Parameter CHUNK, default 4: bits compared per cycle; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request presents operands.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-009 aeqbin, agtbin, altbin  input  1 each  cascade inputs from a less-significant stage.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 aeqb, agtb, altb  output  1 each  registered result flags.
REQ-013 cycles  output  $clog2(NCHUNK+1)  number of chunks examined for this result.

Function
REQ-014 FSM states: IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-015 IDLE, in_valid=1: capture a, b, signed_mode, cascade inputs; set chunk index to NCHUNK-1; go RUN.
REQ-016 Inputs other than out_ready are ignored outside the accept cycle.
REQ-017 RUN, one chunk per cycle, MSB chunk first; compare bits [idx*CHUNK +: CHUNK].
REQ-018 Signed mode: top chunk compared with its MSB inverted on both operands; lower chunks unsigned.
REQ-019 Chunk a>b: agtb=1, go DONE. Chunk a<b: altb=1, go DONE (early termination).
REQ-020 Chunk equal and idx>0: idx decrements, stay RUN.
REQ-021 Chunk equal and idx=0: resolve cascade; exactly one of agtbin/altbin/aeqbin high -> copy to agtb/altb/aeqb; any other cascade pattern -> all three flags 0; go DONE.
REQ-022 cycles = chunks examined, range 1..NCHUNK; out_valid rises cycles clock edges after the accept edge.
REQ-023 DONE: out_valid=1, flags and cycles held stable until out_ready=1; then IDLE the next cycle.
REQ-024 At most one flag high at any time; flags and cycles change only on entry to DONE or on reset.
REQ-025 No new request accepted while in RUN or DONE; no result overwrite.
REQ-026 WIDTH not a multiple of CHUNK, or CHUNK > WIDTH: elaboration error.

Reset
REQ-027 rst=1 at a clock edge: state IDLE, out_valid=0, aeqb=agtb=altb=0, cycles=0, index=NCHUNK-1.
REQ-028 Reset during RUN or DONE aborts the operation; no result is produced for the aborted request.
REQ-029 First cycle after reset deasserts: in_ready=1.

Structure
REQ-030 Shared package holds the state enum (IDLE/RUN/DONE) and a 3-bit result encoding (EQ, GT, LT, NONE).
REQ-031 One sub-module, mag_compare_chunk: combinational CHUNK-bit compare with invert-MSB input, outputs gt/lt/eq.
REQ-032 Top-level holds the FSM, operand registers, index counter, cycle counter, and result registers.

Verification (WIDTH=16, CHUNK=4)
REQ-033 Unsigned a=0x8000, b=0x7FFF -> agtb=1, cycles=1, out_valid 1 edge after accept.
REQ-034 Signed, a=0x8000, b=0x7FFF -> altb=1, cycles=1.
REQ-035 a=0x1334, b=0x1234 -> agtb, cycles=2; a=0x1235, b=0x1234 -> agtb, cycles=4.
REQ-036 a=b=0x1234 with cascade agtbin=1 -> agtb, cycles=4; cascade 000 -> all flags 0, out_valid=1.
REQ-037 out_ready held 0 for 5 cycles in DONE -> flags stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-038 rst pulsed in RUN -> next cycle IDLE, out_valid=0, flags 0, in_ready=1; no stale result appears.
